johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Decoding monitor for the ring and Johnson counters in the counters library: it samples a counter's parallel output and recovers the phase index. Each sample is checked for code legality and for correct single-step progression. Full revolutions and errors are counted. The block sits beside a counter instance, in RTL or on the bench, as the receiving end of its count bus.

## Interface
- N, 10: counter width in bits, N ≥ 2.
- RING_MODE, 0: 0 decodes a Johnson code with 2N states; 1 decodes a one-hot ring code with N states.
- IW, $clog2(2*N): width of the index output, derived locally.
- clk  input  1  clock; all logic on the rising edge.
- reset_ah_in  input  1  reset, synchronous, active-high.
- code_in  input  N  counter output being decoded.
- valid_in  input  1  qualifies code_in for this cycle.
- clear_cnt_in  input  1  synchronous clear of both counters.
- index_out  output  IW  decoded phase index.
- legal_out  output  1  last valid sample was a legal code word.
- lock_out  output  1  monitor is locked to the sequence.
- step_err_out  output  1  one-cycle pulse: legal sample that is not the successor of the previous sample.
- wrap_out  output  1  one-cycle pulse: index advanced from LAST to 0.
- rev_count_out  output  16  revolution count, saturating.
- err_count_out  output  8  error count, saturating.

## Operation
- LAST is 2N−1 for Johnson mode and N−1 for ring mode.
- Johnson code is the left-shifting Johnson sequence: bit0 ← ~bit[N−1]. State 0 is all zeros.
  - State k for 1 ≤ k ≤ N: bits [k−1:0] are ones, the rest are zeros.
  - State N+j for 1 ≤ j ≤ N−1: bits [j−1:0] are zeros, the rest are ones.
  - Legal code: a contiguous run of ones anchored at bit0, or a contiguous run of ones anchored at bit N−1, or all zeros.
  - Index: popcount when bit[N−1]=0; 2N−popcount when bit[N−1]=1. All ones decodes to N.
- Ring code is one-hot and rotates left. State k has only bit k set, so state 0 is 0…01.
  - Legal code: exactly one bit set. Index is the position of that bit.
  - All zeros and multi-hot codes are illegal.
- State machine has two states, UNLOCKED and LOCKED. Only cycles with valid_in=1 are evaluated.
  - In UNLOCKED, a legal sample loads the index and moves to LOCKED. No step_err and no wrap are raised, even if the index is 0.
  - In UNLOCKED, an illegal sample stays in UNLOCKED and increments err.
  - In LOCKED, a legal sample with index equal to prev+1 mod (LAST+1) is normal progress. It loads the index; wrap_out=1 if prev=LAST and the new index is 0, and rev is incremented.
  - In LOCKED, a legal sample with index equal to prev is a hold. Nothing is flagged and the state stays LOCKED.
  - In LOCKED, a legal sample with any other index raises step_err_out=1 and increments err. The index resyncs to the new value and the state stays LOCKED.
  - In any state, an illegal sample sets legal_out=0, holds index_out, moves to UNLOCKED and increments err. step_err_out stays 0.
- Counters:
  - Both counters saturate: rev at 16'hFFFF, err at 8'hFF.
  - clear_cnt_in=1 forces both counters to 0 and takes priority over a same-cycle increment; that event is not counted.
  - clear_cnt_in does not affect lock, index or pulses.
- valid_in=0: index_out, legal_out, lock_out and the counters hold. step_err_out and wrap_out are 0.

## Timing
- All outputs are registered. A sample with valid_in high at edge t is reflected on every output after edge t, i.e. one cycle of latency.
- Pulses (step_err_out, wrap_out) are high for exactly one cycle per triggering sample. Back-to-back valid samples can pulse on consecutive cycles.
- Reset values: index_out=0, legal_out=0, lock_out=0, step_err_out=0, wrap_out=0, rev_count_out=0, err_count_out=0. The FSM resets to UNLOCKED.
- Reset has priority over valid_in and clear_cnt_in. A reset asserted mid-sequence discards the lock; the first legal sample after reset relocks without a step_err.
- Increment comparisons use the registered previous index; no combinational path runs from code_in to any output.

## Test plan
- Johnson, N=4, one valid sample per cycle: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - index_out reads 0…7 then 0.
  - lock_out=1 from the first output cycle.
  - wrap_out pulses once on the last sample; rev_count_out=1; err_count_out=0.
- Johnson, N=4, illegal and skipped codes:
  - After lock at 0011, sample 0101: legal_out=0, lock_out=0, index_out holds 2, err=1.
  - Then sample 0001: relock at index 1 with no step_err.
  - Then sample 1111: step_err_out pulses, index_out=4, err=2.
- Ring, RING_MODE=1, N=4:
  - Samples 0001, 0010, 0100, 1000, 0001 give index 0, 1, 2, 3, 0, with wrap pulsing on the last sample.
  - Sample 0011 is illegal; sample 0000 is illegal; err=2.
- Hold and valid gating:
  - Repeat 0011 for three cycles: no error and no pulse.
  - Toggle valid_in low during the sequence: outputs hold and pulses stay 0.
- Saturation and clear:
  - Drive 300 illegal samples: err_count_out stops at 255.
  - Assert clear_cnt_in on the same cycle as an error: err=0 next cycle.
- Reset mid-operation:
  - With lock=1, index=5 and rev=3, assert reset_ah_in for one cycle: all outputs read 0.
  - Then sample 1100: lock=1, index=6, step_err_out=0.

Source files
------------

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a Johnson or one-hot ring counter bus into a phase index,
// checks single-step progression and counts revolutions and errors.
module johnson_decoder #(
  parameter int N = 10,
  parameter bit RING_MODE = 1'b0,
  localparam int IW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset_ah_in,
  input  logic [N-1:0]  code_in,
  input  logic          valid_in,
  input  logic          clear_cnt_in,
  output logic [IW-1:0] index_out,
  output logic          legal_out,
  output logic          lock_out,
  output logic          step_err_out,
  output logic          wrap_out,
  output logic [15:0]   rev_count_out,
  output logic [7:0]    err_count_out
);
  localparam int LAST = RING_MODE ? N-1 : 2*N-1;
  localparam int PW = $clog2(N+1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] index_q, index_d, dec_idx, pos, nxt;
  logic [PW-1:0] pc;
  logic [N-1:0] inv;
  logic dec_legal, legal_q, legal_d, step_q, step_d, wrap_q, wrap_d, err_inc;
  logic [15:0] rev_q, rev_d;
  logic [7:0] err_q, err_d;
  always_comb begin
    pc = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc + PW'(code_in[i]);
      if (code_in[i]) pos = IW'(i);
    end
  end
  assign inv = ~code_in;
  // Johnson words are a run of ones anchored at bit 0, or a run of zeros anchored at bit 0
  assign dec_legal = RING_MODE ? (code_in != '0 && (code_in & (code_in - N'(1))) == '0)
                               : ((code_in & (code_in + N'(1))) == '0 || (inv & (inv + N'(1))) == '0);
  assign dec_idx = RING_MODE ? pos : (code_in[N-1] ? IW'(2*N) - IW'(pc) : IW'(pc));
  assign nxt = index_q == IW'(LAST) ? '0 : index_q + IW'(1);
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    legal_d = legal_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (valid_in) begin
      legal_d = dec_legal;
      if (!dec_legal) begin
        state_d = UNLOCKED;
      end else begin
        index_d = dec_idx;
        state_d = LOCKED;
        if (state_q == LOCKED) begin
          wrap_d = dec_idx == nxt && index_q == IW'(LAST);
          step_d = dec_idx != nxt && dec_idx != index_q;
        end
      end
    end
    err_inc = valid_in && (!dec_legal || step_d);
    rev_d = clear_cnt_in ? '0 : rev_q + 16'(wrap_d && rev_q != 16'hFFFF);
    err_d = clear_cnt_in ? '0 : err_q + 8'(err_inc && err_q != 8'hFF);
  end
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_q <= UNLOCKED;
      index_q <= '0;
      legal_q <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      rev_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      legal_q <= legal_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      rev_q <= rev_d;
      err_q <= err_d;
    end
  end
  assign index_out = index_q;
  assign legal_out = legal_q;
  assign lock_out = state_q == LOCKED;
  assign step_err_out = step_q;
  assign wrap_out = wrap_q;
  assign rev_count_out = rev_q;
  assign err_count_out = err_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: Johnson and ring instances against a table-lookup reference model via a tagged scoreboard.
module tb_johnson_decoder;
  localparam int N = 4;
  localparam int IW = $clog2(2*N);
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst = 2'b11, vld = 2'b00, clr = 2'b00;
  logic [N-1:0] code [2];
  logic [IW-1:0] o_idx [2];
  logic o_legal [2], o_lock [2], o_step [2], o_wrap [2];
  logic [15:0] o_rev [2];
  logic [7:0] o_err [2];
  int cyc = 0, checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  johnson_decoder #(.N(N), .RING_MODE(1'b0)) dut_j (
    .clk(clk), .reset_ah_in(rst[0]), .code_in(code[0]), .valid_in(vld[0]), .clear_cnt_in(clr[0]),
    .index_out(o_idx[0]), .legal_out(o_legal[0]), .lock_out(o_lock[0]), .step_err_out(o_step[0]),
    .wrap_out(o_wrap[0]), .rev_count_out(o_rev[0]), .err_count_out(o_err[0]));
  johnson_decoder #(.N(N), .RING_MODE(1'b1)) dut_r (
    .clk(clk), .reset_ah_in(rst[1]), .code_in(code[1]), .valid_in(vld[1]), .clear_cnt_in(clr[1]),
    .index_out(o_idx[1]), .legal_out(o_legal[1]), .lock_out(o_lock[1]), .step_err_out(o_step[1]),
    .wrap_out(o_wrap[1]), .rev_count_out(o_rev[1]), .err_count_out(o_err[1]));
  typedef struct {
    int tag;
    int d;
    int idx;
    int legal;
    int lock;
    int step;
    int wrap;
    int rev;
    int err;
  } exp_t;
  exp_t q[$];
  int m_lock [2], m_idx [2], m_legal [2], m_rev [2], m_err [2];
  function automatic int states(int d);
    return d == 1 ? N : 2*N;
  endfunction
  function automatic logic [N-1:0] code_of(int d, int k);
    int w;
    if (d == 1) w = 1 << k;
    else if (k <= N) w = (1 << k) - 1;
    else w = ((1 << N) - 1) & ~((1 << (k - N)) - 1);
    return w[N-1:0];
  endfunction
  function automatic int lookup(int d, logic [N-1:0] c);
    for (int k = 0; k < states(d); k++) if (code_of(d, k) == c) return k;
    return -1;
  endfunction
  task automatic model(input int d, input bit r, input bit vv, input bit cl, input logic [N-1:0] c, output exp_t e);
    int m, i;
    bit st, wr, ei;
    m = states(d);
    st = 0;
    wr = 0;
    ei = 0;
    if (r) begin
      m_lock[d] = 0; m_idx[d] = 0; m_legal[d] = 0; m_rev[d] = 0; m_err[d] = 0;
    end else begin
      if (vv) begin
        i = lookup(d, c);
        if (i < 0) begin
          m_legal[d] = 0; m_lock[d] = 0; ei = 1;
        end else begin
          m_legal[d] = 1;
          if (m_lock[d] == 1) begin
            if (i == (m_idx[d] + 1) % m) wr = (m_idx[d] == m - 1);
            else if (i != m_idx[d]) begin st = 1; ei = 1; end
          end
          m_idx[d] = i;
          m_lock[d] = 1;
        end
      end
      if (cl) begin
        m_rev[d] = 0; m_err[d] = 0;
      end else begin
        if (wr && m_rev[d] < 65535) m_rev[d]++;
        if (ei && m_err[d] < 255) m_err[d]++;
      end
    end
    e.d = d; e.idx = m_idx[d]; e.legal = m_legal[d]; e.lock = m_lock[d];
    e.step = st; e.wrap = wr; e.rev = m_rev[d]; e.err = m_err[d];
  endtask
  task automatic step(input int d, input bit r, input bit vv, input bit cl, input logic [N-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst[d] = r; vld[d] = vv; clr[d] = cl; code[d] = c;
    rst[1-d] = 1'b0; vld[1-d] = 1'b0; clr[1-d] = 1'b0;
    model(d, r, vv, cl, c, e);
    e.tag = cyc + 1;
    q.push_back(e);
  endtask
  task automatic chk(input string name, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0d exp=%0d", name, d, cyc, act, expv);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        chk("index", e.d, int'(o_idx[e.d]), e.idx);
        chk("legal", e.d, int'(o_legal[e.d]), e.legal);
        chk("lock", e.d, int'(o_lock[e.d]), e.lock);
        chk("step_err", e.d, int'(o_step[e.d]), e.step);
        chk("wrap", e.d, int'(o_wrap[e.d]), e.wrap);
        chk("rev_count", e.d, int'(o_rev[e.d]), e.rev);
        chk("err_count", e.d, int'(o_err[e.d]), e.err);
      end
    end
  end
  task automatic rand_run(input int d, input int cycles);
    int p, r;
    logic [N-1:0] c;
    p = 0;
    for (int n = 0; n < cycles; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) p = (p + 1) % states(d);
      else if (r < 87 && r >= 80) p = $urandom_range(0, states(d) - 1);
      c = code_of(d, p);
      if (r >= 93) c = N'($urandom);
      else if (r >= 87) c = N'($urandom) | code_of(d, p);
      step(d, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3, c);
    end
  endtask
  initial begin
    code[0] = '0;
    code[1] = '0;
    step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    for (int k = 0; k <= 2*N; k++) step(0, 0, 1, 0, code_of(0, k % (2*N)));
    step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, 4'b0011);
    step(0, 0, 1, 0, 4'b0101);
    step(0, 0, 1, 0, 4'b0001);
    step(0, 0, 1, 0, 4'b1111);
    for (int k = 0; k <= N; k++) step(1, 0, 1, 0, code_of(1, k % N));
    step(1, 0, 1, 0, 4'b0011);
    step(1, 0, 1, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0011);
    step(0, 0, 1, 0, 4'b0011);
    step(0, 0, 1, 0, 4'b0011);
    step(0, 0, 0, 0, 4'b1111);
    step(0, 0, 1, 0, 4'b0111);
    step(0, 0, 0, 0, 4'b0101);
    step(0, 0, 1, 0, 4'b1111);
    for (int k = 0; k < 300; k++) step(0, 0, 1, 0, 4'b0101);
    step(0, 0, 1, 1, 4'b0101);
    step(0, 0, 1, 0, 4'b0101);
    step(0, 1, 0, 0, '0);
    for (int k = 0; k <= 3*2*N + 5; k++) step(0, 0, 1, 0, code_of(0, k % (2*N)));
    step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, 4'b1100);
    step(0, 0, 1, 0, 4'b1000);
    rand_run(0, 500);
    rand_run(1, 500);
    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_drained", 0, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
